// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer-width helper and Gray/binary conversions shared by both FIFO pointer controllers.
// Conversions work on MAX_W-bit zero-extended values, so any pointer width up to MAX_W can use them.
package fifo_pkg;
    localparam int MAX_W = 32;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < MAX_W; i++) b = b ^ (g >> i);
        return b;
    endfunction
endpackage

// File: rtl/gray_ptr_cnt.sv
// gray_ptr_cnt: binary + Gray pointer register pair with increment enable.
// The Gray value is a flop output, so it can feed a synchronizer directly.
module gray_ptr_cnt
    import fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_bin,
    output logic [W-1:0] o_bin_next,
    output logic [W-1:0] o_gray,
    output logic [W-1:0] o_gray_next
);
    logic [W-1:0] bin_q, bin_d, gray_q, gray_d;

    always_comb begin
        bin_d  = bin_q + W'(i_inc);
        gray_d = W'(bin2gray(MAX_W'(bin_d)));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign o_bin       = bin_q;
    assign o_bin_next  = bin_d;
    assign o_gray      = gray_q;
    assign o_gray_next = gray_d;
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain pointer and flag controller of the async FIFO.
// Flags are computed from the next pointer so they move on the same edge as the write.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic                  i_clr_ovf,
    input  logic [ADDR_WIDTH:0]   i_rptr_gray_sync,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH:0]   o_wptr_gray,
    output logic                  o_full,
    output logic                  o_afull,
    output logic [ADDR_WIDTH:0]   o_wr_count,
    output logic                  o_overflow
);
    localparam int PW = ptr_width(ADDR_WIDTH);

    logic          accept, set_ovf;
    logic [PW-1:0] wbin, wbin_next, wgray_next, rbin, count_d, count_q;
    logic          full_d, full_q, afull_d, afull_q, ovf_d, ovf_q;
    logic          unused_wbin_msb;

    gray_ptr_cnt #(.W(PW)) u_wptr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_inc       (accept),
        .o_bin       (wbin),
        .o_bin_next  (wbin_next),
        .o_gray      (o_wptr_gray),
        .o_gray_next (wgray_next)
    );

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    always_comb begin
        accept  = i_wr_en & ~full_q;
        set_ovf = i_wr_en & full_q;
        rbin    = PW'(gray2bin(MAX_W'(i_rptr_gray_sync)));
        full_d  = wgray_next == (i_rptr_gray_sync ^ {2'b11, {(PW-2){1'b0}}});
        count_d = wbin_next - rbin;
        afull_d = count_d >= PW'(AFULL_THRESH);
        ovf_d   = set_ovf | (ovf_q & ~i_clr_ovf);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign unused_wbin_msb = wbin[PW-1];
    assign o_wr_addr       = wbin[ADDR_WIDTH-1:0];
    assign o_mem_we        = accept;
    assign o_full          = full_q;
    assign o_afull         = afull_q;
    assign o_wr_count      = count_q;
    assign o_overflow      = ovf_q;
endmodule
